// File: rtl/reg_file_mp_if.sv
// reg_file_mp_if: read, write and scoreboard bus of the multi-port register file.
interface reg_file_mp_if #(
   parameter int DATA_W = 32,
   parameter int ADDR_W = 5,
   parameter int NUM_RD = 2
);
   logic [NUM_RD*ADDR_W-1:0] rd_addr;
   logic [NUM_RD*DATA_W-1:0] rd_data;
   logic [NUM_RD-1:0]        rd_busy;
   logic                     wr_en;
   logic [ADDR_W-1:0]        wr_addr;
   logic [DATA_W-1:0]        wr_data;
   logic                     sb_set;
   logic [ADDR_W-1:0]        sb_addr;
   logic                     sb_clr_all;
   modport master (
      output rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr, sb_clr_all,
      input  rd_data, rd_busy
   );
   modport slave (
      input  rd_addr, wr_en, wr_addr, wr_data, sb_set, sb_addr, sb_clr_all,
      output rd_data, rd_busy
   );
endinterface

// File: rtl/reg_file_mp.sv
// reg_file_mp: parametrised multi-read-port register file with pending-write scoreboard.
// Define REGFILE_BYPASS_EN to forward a same-cycle write to matching read ports.
module reg_file_mp #(
   parameter int DATA_W   = 32,
   parameter int DEPTH    = 32,
   parameter int ADDR_W   = $clog2(DEPTH),
   parameter int NUM_RD   = 2,
   parameter int ZERO_REG = 1
) (
   input logic          clk,
   input logic          rst,
   reg_file_mp_if.slave bus
);
   localparam bit ZR = ZERO_REG != 0;
   logic [DATA_W-1:0]        mem [DEPTH];
   logic [DEPTH-1:0]         pend, pend_nxt;
   logic [NUM_RD*DATA_W-1:0] rd_data_c;
   logic [NUM_RD-1:0]        rd_busy_c;
   logic [ADDR_W-1:0]        ra;
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         for (int i = 0; i < DEPTH; i++) mem[i] <= '0;
         pend <= '0;
      end else begin
         if (bus.wr_en && !(ZR && bus.wr_addr == '0)) mem[bus.wr_addr] <= bus.wr_data;
         pend <= pend_nxt;
      end
   end
   // set is applied after the write-clear so a new producer wins on the same address
   always_comb begin
      pend_nxt = pend;
      if (bus.sb_clr_all) pend_nxt = '0;
      else begin
         if (bus.wr_en) pend_nxt[bus.wr_addr] = 1'b0;
         if (bus.sb_set) pend_nxt[bus.sb_addr] = 1'b1;
      end
      if (ZR) pend_nxt[0] = 1'b0;
   end
   always_comb begin
      rd_data_c = '0;
      rd_busy_c = '0;
      ra = '0;
      for (int k = 0; k < NUM_RD; k++) begin
         ra = bus.rd_addr[k*ADDR_W +: ADDR_W];
         if (!rst && !(ZR && ra == '0)) begin
`ifdef REGFILE_BYPASS_EN
            if (bus.wr_en && bus.wr_addr == ra) begin
               rd_data_c[k*DATA_W +: DATA_W] = bus.wr_data;
               rd_busy_c[k] = bus.sb_set && bus.sb_addr == ra;
            end else begin
               rd_data_c[k*DATA_W +: DATA_W] = mem[ra];
               rd_busy_c[k] = pend[ra];
            end
`else
            rd_data_c[k*DATA_W +: DATA_W] = mem[ra];
            rd_busy_c[k] = pend[ra];
`endif
         end
      end
   end
   assign bus.rd_data = rd_data_c;
   assign bus.rd_busy = rd_busy_c;
endmodule

// File: doc/reg_file_mp.md
Name: reg_file_mp

Overview:
- Parametrised multi-read-port register file for the MIPS pipeline.
- Generalises the 32x32, 2-read-port file in width, depth and read-port count.
- Adds a gated write, a hard-wired zero register and a per-register pending-write scoreboard.
- Decode reads operands and busy flags; writeback writes results and clears busy flags; optional write-to-read bypass.

Parameters:
- DATA_W, 32, register width in bits.
- DEPTH, 32, number of registers; power of two, at least 2.
- ADDR_W, $clog2(DEPTH), address width; derived, do not override.
- NUM_RD, 2, number of independent read ports, 1..8.
- ZERO_REG, 1, 1: register 0 reads 0, ignores writes, is never busy; 0: register 0 is ordinary.

Ports:
- clk  in  1  clock; all state updates on rising edge.
- rst  in  1  asynchronous, active-high reset.
- rd_addr  in  NUM_RD*ADDR_W  packed read addresses; port k at [k*ADDR_W +: ADDR_W].
- rd_data  out  NUM_RD*DATA_W  packed read data; port k at [k*DATA_W +: DATA_W].
- rd_busy  out  NUM_RD  pending-write flag of the register addressed by port k.
- wr_en  in  1  write enable.
- wr_addr  in  ADDR_W  write address.
- wr_data  in  DATA_W  write data.
- sb_set  in  1  mark sb_addr as pending (producer issued).
- sb_addr  in  ADDR_W  scoreboard set address.
- sb_clr_all  in  1  flush: clear all pending bits (pipeline squash).

Behaviour:
- Reset: asserting rst immediately clears all registers and all pending bits, independent of clk.
  - While rst is high, every rd_data is 0 and every rd_busy is 0.
  - Reset asserted mid-operation discards any write in flight.
  - The first write after deassertion is taken on the first rising edge at which rst is low.
- Read: purely combinational, zero latency.
  - rd_data[k] = reg[rd_addr[k]]; rd_busy[k] = pend[rd_addr[k]].
  - Any number of ports may address the same register.
- Write: on a rising edge with wr_en=1, reg[wr_addr] <= wr_data.
  - wr_en=0 leaves the array unchanged, including when wr_data is nonzero.
- Zero register (ZERO_REG=1):
  - Writes to address 0 are dropped and sb_set to address 0 is ignored.
  - Reads of address 0 return 0 and busy 0 regardless of bypass.
- Scoreboard, one pending bit per register, evaluated per rising edge in priority order:
  1. sb_clr_all=1: all bits cleared; sb_set and the write-clear are ignored this edge.
  2. sb_set=1: pend[sb_addr] <= 1.
  3. wr_en=1 and wr_addr != sb_addr (or sb_set=0): pend[wr_addr] <= 0.
- Simultaneous sb_set and wr_en to the same address: set wins and the bit ends at 1, since a new producer supersedes the retiring one. The data write still occurs.
- The scoreboard only reports hazards; it never blocks a write or a read.

Optional Feature:
- Macro: REGFILE_BYPASS_EN.
- Defined: for each port k, when wr_en=1 and wr_addr == rd_addr[k] (and not zero register under ZERO_REG=1):
  - rd_data[k] = wr_data in the same cycle.
  - rd_busy[k] = 0 unless sb_set also targets that address in that cycle.
  - Result: write-then-read in one cycle needs no stall.
- Not defined: reads return the stored array value only; the new value is visible the cycle after the write edge.
- Array contents and scoreboard updates are identical in both builds.

Test Plan:
- Reset mid-stream: fill r1..r31 with 0xA5A5_0000+i, then assert rst asynchronously between edges -> all rd_data=0 and rd_busy=0 immediately. After release, reading r5 gives 0.
- Write gating: wr_en=0, wr_addr=3, wr_data=0xDEADBEEF for 3 cycles -> r3 stays 0. wr_en=1 for one edge -> r3 reads 0xDEADBEEF on both ports.
- Zero register: write 0x1234 to r0 and sb_set to r0 -> rd_data=0 and rd_busy=0 on all ports. Repeat with ZERO_REG=0 -> r0 reads 0x1234 and busy=1.
- Scoreboard: sb_set r7 -> rd_busy=1 next cycle. Write r7=0x55 -> busy=0 and data 0x55. Same edge sb_set r7 plus wr_en r7=0x66 -> busy=1 and data 0x66. sb_clr_all with sb_set r9 -> r7 and r9 both not busy.
- Bypass with NUM_RD=4, DEPTH=64: wr_en r40=0x0F0F, all ports read r40 in that cycle.
  - REGFILE_BYPASS_EN defined -> all four ports show 0x0F0F in-cycle.
  - Not defined -> old value in-cycle, 0x0F0F after the edge.
